// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: detector verdict and pipeline status in,
// stall/flush strobes and EX forwarding selects out.
interface hazard_ctrl_if;
  logic       conf;
  logic [3:0] ctype;
  logic       BranchTakenE;
  logic       MemReady;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output conf, ctype, BranchTakenE, MemReady,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  conf, ctype, BranchTakenE, MemReady,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stalls, flushes, one-bubble load-use, EX forwarding.
// Optional saturating perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_if.slave       hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
`endif
);

  typedef enum logic [1:0] {StRun, StLstall, StBflush} state_e;

  state_e     state_q, state_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic [1:0] fwd_a_dec, fwd_b_dec;
  logic       freeze, branch, load_use_req, bubble;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  assign freeze       = ~hz.MemReady;
  assign branch       = hz.MemReady & hz.BranchTakenE;
  assign load_use_req = hz.conf & ((hz.ctype == 4'd3) | (hz.ctype == 4'd4));
  // A bubble is only inserted from RUN; LSTALL/BFLUSH both mean D cannot be a fresh consumer.
  assign bubble       = hz.MemReady & ~hz.BranchTakenE & load_use_req & (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (freeze) begin
      state_d = state_q;
    end else if (branch) begin
      state_d = StBflush;
    end else begin
      unique case (state_q)
        StRun:    state_d = load_use_req ? StLstall : StRun;
        StLstall: state_d = StRun;
        StBflush: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (branch) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (bubble) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    fwd_a_dec = 2'b00;
    fwd_b_dec = 2'b00;
    if (hz.conf) begin
      case (hz.ctype)
        4'd1:       fwd_a_dec = 2'b10;
        4'd2:       fwd_b_dec = 2'b10;
        4'd5, 4'd7: fwd_a_dec = 2'b01;
        4'd6, 4'd8: fwd_b_dec = 2'b01;
        default:    ;
      endcase
    end
  end

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!freeze) begin
      fwd_a_d = flush_e ? 2'b00 : fwd_a_dec;
      fwd_b_d = flush_e ? 2'b00 : fwd_b_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.ForwardAE = fwd_a_q;
  assign hz.ForwardBE = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bubble && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (branch && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
